// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared constants and the FIFO entry type for the UART receive path.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DEFAULT_DATA_BITS = 8;
    localparam int DEFAULT_DEPTH     = 16;

    typedef struct packed {
        logic                         perr;
        logic [DEFAULT_DATA_BITS-1:0] data;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/uart_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_ram
// Brief    : DEPTH x WIDTH storage, synchronous write, asynchronous read, no reset.
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_ram #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Receive FIFO behind a UART receiver, with overflow and parity stats.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int DEPTH     = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_BITS-1:0]   in_data,
    input  logic                   in_vld,
    input  logic                   in_perr,
    output logic [DATA_BITS-1:0]   out_data,
    output logic                   out_perr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    input  logic                   clr_ovf,
    output logic [7:0]             perr_cnt
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_WORD_W = DATA_BITS + 1;

    logic               in_vld_q, in_vld_d;
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         perr_cnt_q, perr_cnt_d;

    logic                w_wr_evt, w_rd, w_wr_acc, w_drop;
    logic [c_WORD_W-1:0] w_wr_word, w_rd_word;

    // Edge-detect the valid level; a full FIFO still takes a write if a read frees a slot.
    assign w_wr_evt = in_vld & ~in_vld_q;
    assign w_rd     = ~empty_q & out_ready;
    assign w_wr_acc = w_wr_evt & (~full_q | w_rd);
    assign w_drop   = w_wr_evt & full_q & ~w_rd;

    always_comb begin
        in_vld_d   = in_vld;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        perr_cnt_d = perr_cnt_q;

        if (w_wr_acc) begin
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_rd) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end
        if (w_wr_acc && !w_rd) begin
            count_d = count_q + c_CNT_W'(1);
        end else if (!w_wr_acc && w_rd) begin
            count_d = count_q - c_CNT_W'(1);
        end

        if (w_drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end

        if (w_wr_acc && in_perr && (perr_cnt_q != 8'hFF)) begin
            perr_cnt_d = perr_cnt_q + 8'd1;
        end

        full_d  = (count_d == c_CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_vld_q   <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            perr_cnt_q <= '0;
        end else begin
            in_vld_q   <= in_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            perr_cnt_q <= perr_cnt_d;
        end
    end

    // The shared entry type only fits the default character width.
    generate
        if (DATA_BITS == DEFAULT_DATA_BITS) begin : g_pkg_entry
            entry_t w_wr_entry;
            entry_t w_rd_entry;
            always_comb begin
                w_wr_entry.perr = in_perr;
                w_wr_entry.data = in_data;
            end
            assign w_wr_word  = w_wr_entry;
            assign w_rd_entry = w_rd_word;
            assign out_perr   = w_rd_entry.perr;
            assign out_data   = w_rd_entry.data;
        end else begin : g_raw_entry
            assign w_wr_word = {in_perr, in_data};
            assign out_perr  = w_rd_word[DATA_BITS];
            assign out_data  = w_rd_word[DATA_BITS-1:0];
        end
    endgenerate

    uart_fifo_ram #(
        .WIDTH (c_WORD_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (wr_ptr_q),
        .i_wr_data (w_wr_word),
        .i_rd_addr (rd_ptr_q),
        .o_rd_data (w_rd_word)
    );

    assign out_valid = ~empty_q;
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign overflow  = overflow_q;
    assign perr_cnt  = perr_cnt_q;

endmodule
`default_nettype wire
